// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, frame width,
// stop-bit encodings and small helpers used by the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] STOP_ONE     = 2'd0;
  localparam logic [1:0] STOP_ONE_ALT = 2'd1;
  localparam logic [1:0] STOP_TWO     = 2'd2;
  localparam logic [1:0] STOP_TWO_ALT = 2'd3;

  function automatic logic is_two_stop(input logic [1:0] sb);
    logic two;
    two = 1'b0;
    case (sb)
      STOP_ONE, STOP_ONE_ALT: two = 1'b0;
      STOP_TWO, STOP_TWO_ALT: two = 1'b1;
      default:                two = 1'b0;
    endcase
    return two;
  endfunction

  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Phase-accumulator bit-rate generator: tick marks the last cycle of each
// bit period. Rates at or above the clock tick every cycle; zero never ticks.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [31:0] baud_rate,
  output logic        tick
);

  localparam logic [32:0] CLK_FREQ_W = 33'(CLK_FREQ);

  logic [32:0] acc_q;
  logic [32:0] acc_d;
  logic [32:0] acc_next;
  logic [32:0] baud_w;

  assign baud_w = {1'b0, baud_rate};

  // Saturating fast rates to a zero accumulator keeps acc below CLK_FREQ,
  // so the 33-bit sum can never wrap.
  always_comb begin
    acc_next = acc_q + baud_w;
    acc_d    = acc_next;
    tick     = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (baud_w >= CLK_FREQ_W) begin
      tick  = 1'b1;
      acc_d = '0;
    end else if (acc_next >= CLK_FREQ_W) begin
      tick  = 1'b1;
      acc_d = acc_next - CLK_FREQ_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches byte and line settings on accept, then shifts
// start, data (LSB first), optional parity and one or two stop bits.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | driving the start bit (low)
// DATA   | shifting out data bits, LSB first
// PARITY | driving the parity bit
// STOP   | driving one or two stop bits (high)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] baud_rate,
  input  logic        parity_en,
  input  logic        parity_odd,
  input  logic [1:0]  stop_bits,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [31:0] baud_q, baud_d;
  logic        parity_en_q, parity_en_d;
  logic        parity_bit_q, parity_bit_d;
  logic        two_stop_q, two_stop_d;
  logic        tx_q, tx_d;
  logic        tx_ready_q, tx_ready_d;
  logic        tx_done_q, tx_done_d;

  logic transfer;
  logic tick;

  assign transfer = tx_valid && tx_ready_q;

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (transfer),
    .baud_rate (baud_q),
    .tick      (tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    baud_d       = baud_q;
    parity_en_d  = parity_en_q;
    parity_bit_d = parity_bit_q;
    two_stop_d   = two_stop_q;
    tx_d         = tx_q;
    tx_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (transfer) begin
          shift_d      = tx_data;
          baud_d       = baud_rate;
          parity_en_d  = parity_en;
          parity_bit_d = calc_parity(tx_data, parity_odd);
          two_stop_d   = is_two_stop(stop_bits);
          bit_cnt_d    = '0;
          stop_cnt_d   = 1'b0;
          tx_d         = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        if (tick) begin
          bit_cnt_d = LAST_BIT;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == '0) begin
            if (parity_en_q) begin
              tx_d    = parity_bit_q;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = two_stop_q;
              state_d    = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = two_stop_q;
          state_d    = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (stop_cnt_q == 1'b0) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_cnt_d = 1'b0;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    tx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      baud_q       <= '0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      two_stop_q   <= 1'b0;
      tx_q         <= 1'b1;
      tx_ready_q   <= 1'b1;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      baud_q       <= baud_d;
      parity_en_q  <= parity_en_d;
      parity_bit_q <= parity_bit_d;
      two_stop_q   <= two_stop_d;
      tx_q         <= tx_d;
      tx_ready_q   <= tx_ready_d;
      tx_done_q    <= tx_done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = ~tx_ready_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line levels are queued per frame at
// stimulus time and popped bit by bit while the serial line is sampled.
module tb_uart_tx;

  localparam int CLK_FREQ = 1_000_000;

  logic        clk;
  logic        rst;
  logic [31:0] baud_rate;
  logic        parity_en;
  logic        parity_odd;
  logic [1:0]  stop_bits;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic        tx_done;

  uart_tx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_rate  (baud_rate),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop_bits  (stop_bits),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic lvl;
    int   cyc;
  } bit_t;

  bit_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb_of(input int unsigned baud);
    if (baud >= CLK_FREQ) return 1;
    return CLK_FREQ / baud;
  endfunction

  task automatic push_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic two, input int cpb, output int n);
    n = 0;
    exp_q.push_back('{1'b0, cpb}); n++;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{d[i], cpb}); n++;
    end
    if (pen) begin
      exp_q.push_back('{(^d) ^ podd, cpb}); n++;
    end
    exp_q.push_back('{1'b1, cpb}); n++;
    if (two) begin
      exp_q.push_back('{1'b1, cpb}); n++;
    end
  endtask

  // Pops n expected bits; each bit must hold its level for its full length
  // with busy high and no tx_done.
  task automatic check_frame(input string tag, input int n);
    bit_t e;
    int   bad;
    logic last_tx;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        return;
      end
      e       = exp_q.pop_front();
      bad     = 0;
      last_tx = e.lvl;
      for (int c = 0; c < e.cyc; c++) begin
        @(negedge clk);
        if (tx !== e.lvl || busy !== 1'b1 || tx_done !== 1'b0) begin
          bad++;
          last_tx = tx;
        end
      end
      checks++;
      assert (bad == 0)
      else begin
        errors++;
        $error("FAIL %s_bit%0d observed tx=%0b bad_cycles=%0d expected tx=%0b bad_cycles=0",
               tag, k, last_tx, bad, e.lvl);
      end
    end
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    chk({tag, "_done"},  {31'd0, tx_done},  32'd1);
    chk({tag, "_tx_idle"}, {31'd0, tx},     32'd1);
    chk({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    chk({tag, "_done_clr"}, {31'd0, tx_done}, 32'd0);
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    int n, n2, cnt;

    rst        = 1'b1;
    baud_rate  = 32'd100_000;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop_bits  = 2'd0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    {31'd0, tx},       32'd1);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_done",  {31'd0, tx_done},  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x55, no parity, one stop bit
    push_frame(8'h55, 1'b0, 1'b0, 1'b0, cpb_of(baud_rate), n);
    start_tx(8'h55);
    check_frame("f55", n);
    check_done("f55");

    // 0x07 with even then odd parity
    parity_en = 1'b1;
    push_frame(8'h07, 1'b1, 1'b0, 1'b0, 10, n);
    start_tx(8'h07);
    check_frame("f07_even", n);
    check_done("f07_even");
    parity_odd = 1'b1;
    push_frame(8'h07, 1'b1, 1'b1, 1'b0, 10, n);
    start_tx(8'h07);
    check_frame("f07_odd", n);
    check_done("f07_odd");
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // two stop bits
    stop_bits = 2'd2;
    push_frame(8'hA3, 1'b0, 1'b0, 1'b1, 10, n);
    start_tx(8'hA3);
    check_frame("fA3_2stop", n);
    check_done("fA3_2stop");
    stop_bits = 2'd3;
    push_frame(8'h3C, 1'b0, 1'b0, 1'b1, 10, n);
    start_tx(8'h3C);
    check_frame("f3C_2stop", n);
    check_done("f3C_2stop");
    stop_bits = 2'd1;

    // back-to-back with tx_valid held high
    push_frame(8'h11, 1'b0, 1'b0, 1'b0, 10, n);
    push_frame(8'h22, 1'b0, 1'b0, 1'b0, 10, n2);
    @(negedge clk);
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'h22;
    check_frame("b2b_11", n);
    @(negedge clk);
    chk("b2b_gap_done",  {31'd0, tx_done},  32'd1);
    chk("b2b_gap_tx",    {31'd0, tx},       32'd1);
    chk("b2b_gap_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_frame("b2b_22", n2);
    check_done("b2b_22");

    // config change mid-frame must only affect the next frame
    stop_bits = 2'd0;
    push_frame(8'h3C, 1'b0, 1'b0, 1'b0, 10, n);
    start_tx(8'h3C);
    fork
      check_frame("chg_cur", n);
      begin
        repeat (30) @(negedge clk);
        baud_rate = 32'd50_000;
        parity_en = 1'b1;
      end
    join
    check_done("chg_cur");
    push_frame(8'hC5, 1'b1, 1'b0, 1'b0, 20, n);
    start_tx(8'hC5);
    check_frame("chg_next", n);
    check_done("chg_next");
    baud_rate = 32'd100_000;
    parity_en = 1'b0;

    // reset mid-frame aborts without tx_done
    start_tx(8'h55);
    repeat (45) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx",    {31'd0, tx},       32'd1);
    chk("abort_ready", {31'd0, tx_ready}, 32'd1);
    chk("abort_busy",  {31'd0, busy},     32'd0);
    chk("abort_done",  {31'd0, tx_done},  32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx !== 1'b1) cnt++;
    end
    chk("abort_quiet", cnt, 32'd0);
    push_frame(8'h55, 1'b0, 1'b0, 1'b0, 10, n);
    start_tx(8'h55);
    check_frame("after_abort", n);
    check_done("after_abort");

    // baud_rate at clock frequency: one cycle per bit
    baud_rate  = 32'd1_000_000;
    parity_en  = 1'b1;
    parity_odd = 1'b1;
    push_frame(8'h96, 1'b1, 1'b1, 1'b0, cpb_of(baud_rate), n);
    start_tx(8'h96);
    check_frame("fast", n);
    check_done("fast");
    baud_rate = 32'd7_000_000;
    parity_en = 1'b0;
    push_frame(8'h69, 1'b0, 1'b0, 1'b0, 1, n);
    start_tx(8'h69);
    check_frame("over", n);
    check_done("over");

    // baud_rate zero holds the start bit until reset
    baud_rate = 32'd0;
    start_tx(8'hFF);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b0 || busy !== 1'b1 || tx_done !== 1'b0) cnt++;
    end
    chk("zero_hold", cnt, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("zero_rst_tx",    {31'd0, tx},       32'd1);
    chk("zero_rst_ready", {31'd0, tx_ready}, 32'd1);
    baud_rate = 32'd100_000;
    push_frame(8'hE1, 1'b0, 1'b0, 1'b0, 10, n);
    start_tx(8'hE1);
    check_frame("recover", n);
    check_done("recover");

    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, system clock frequency in Hz; SHALL be > 0.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 baud_rate  input  32  bits per second, from the config register block.
REQ-005 parity_en  input  1  1 = parity bit appended.
REQ-006 parity_odd  input  1  1 = odd parity, 0 = even.
REQ-007 stop_bits  input  2  0/1 = one stop bit, 2/3 = two stop bits.
REQ-008 tx_data  input  8  byte to send.
REQ-009 tx_valid  input  1  tx_data valid.
REQ-010 tx_ready  output  1  block can accept a byte.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  frame in progress.
REQ-013 tx_done  output  1  one-cycle pulse at end of last stop bit.

Function
REQ-014 Transfer SHALL occur on the rising edge where tx_valid && tx_ready; tx_data, baud_rate, parity_en, parity_odd and stop_bits SHALL be latched then, and later input changes SHALL NOT affect the frame in flight.
REQ-015 tx_ready SHALL equal (state == IDLE), registered; busy SHALL equal !tx_ready.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE->START on transfer.
- START->DATA on tick.
- DATA->(PARITY if parity_en, else STOP) on the 8th tick.
- PARITY->STOP on tick.
- STOP->IDLE on the 1st tick (one stop bit) or 2nd tick (two stop bits).
REQ-017 tx SHALL be registered: 1 in IDLE and STOP, 0 in START, data bit in DATA (LSB first), parity bit in PARITY.
REQ-018 Parity bit SHALL be XOR of the 8 data bits, inverted when parity_odd = 1.
REQ-019 Bit timing SHALL use a phase accumulator:
- acc_next = acc + baud_rate, computed at 33 bits.
- tick when acc_next >= CLK_FREQ, then acc <= acc_next - CLK_FREQ; otherwise acc <= acc_next.
REQ-020 acc SHALL clear to 0 on transfer, so tx falls to 0 on the cycle after transfer and the start bit lasts a full period.
REQ-021 baud_rate >= CLK_FREQ SHALL produce a tick every cycle; baud_rate = 0 SHALL produce no tick, holding the current bit indefinitely (no lockup beyond rst).
REQ-022 tx_done SHALL pulse for one cycle in the cycle the FSM leaves STOP.
REQ-023 After tx_done, IDLE SHALL last at least one cycle before the next start bit.

Reset
REQ-024 rst SHALL win over all other inputs in the same cycle.
REQ-025 Values after rst: state IDLE, tx = 1, tx_ready = 1, busy = 0, tx_done = 0, acc = 0, bit counter = 0.
REQ-026 rst asserted mid-frame SHALL abort the frame, with tx = 1 on the following cycle and no tx_done.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state enum, UART_DATA_BITS = 8 and the stop_bits encodings.
REQ-028 Bit timing SHALL live in sub-module uart_baud_gen:
- inputs: clk, rst, clear, baud_rate.
- output: tick.
- parameter: CLK_FREQ.
REQ-029 uart_tx SHALL contain only the FSM, shift register, bit and stop counters, and parity logic.

Verification (CLK_FREQ = 1_000_000, baud_rate = 100_000, i.e. 10 cycles/bit)
REQ-030 Send 0x55, parity off, one stop bit -> tx = 0,1,0,1,0,1,0,1,0,1 (start, then LSB first, then stop), each bit 10 cycles; tx_done 100 cycles after transfer.
REQ-031 Send 0x07 with parity_en = 1 -> parity bit 1 when parity_odd = 0 and 0 when parity_odd = 1; frame = 110 cycles.
REQ-032 stop_bits = 2, byte 0xA3 -> stop high for 20 cycles; tx_done at cycle 110.
REQ-033 tx_valid held high for 0x11 then 0x22 -> two frames of 100 cycles, separated by exactly 1 idle-high cycle, data intact.
REQ-034 Change baud_rate to 50_000 and parity_en to 1 at cycle 30 of a frame -> the current frame keeps 10-cycle bits and no parity; the next frame uses 20-cycle bits with parity.
REQ-035 Assert rst at cycle 45 of a frame -> tx = 1, tx_ready = 1 on the next cycle; no tx_done; a following 0x55 frame matches REQ-030.
